// File: rtl/data_memory.sv
// data_memory: data RAM for the single-cycle RV32I core.
// CPU port: byte-addressed, combinational load with sign/zero extension and
// byte-enable masked synchronous store. VGA port: registered read-only word
// port. Misaligned accesses and illegal store widths raise a sticky error flag.
module data_memory #(
    parameter int DEPTH_WORDS = 1024,
    parameter int VGA_ADDR_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           addr,
    input  logic [31:0]           wr_data,
    input  logic                  dm_write,
    input  logic [2:0]            dm_ctrl,
    output logic [31:0]           rd_data,
    output logic                  misalign_err,
    input  logic                  err_clr,
    input  logic [VGA_ADDR_W-1:0] vga_addr,
    output logic [31:0]           vga_data
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // funct3 encodings of the access width
    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    logic [31:0] mem [DEPTH_WORDS];

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic [31:0]      cpu_word;
    logic [7:0]       byte_sel;
    logic [15:0]      half_sel;

    logic             misaligned;
    logic             store_width_ok;
    logic             fault;
    logic             wr_en;
    logic [3:0]       byte_en;
    logic [31:0]      wr_lanes;

    logic             misalign_err_d, misalign_err_q;
    logic [31:0]      vga_data_q;

    // Upper address bits wrap silently; fold them into an ignored signal.
    logic             unused_addr_bits;
    assign unused_addr_bits = ^addr[31:IDX_W+2];

    assign word_idx = addr[IDX_W+1:2];
    assign lane     = addr[1:0];
    assign cpu_word = mem[word_idx];
    assign byte_sel = cpu_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? cpu_word[31:16] : cpu_word[15:0];

    // Fault detection and store enables; no write while reset is asserted.
    always_comb begin
        misaligned     = 1'b0;
        store_width_ok = 1'b0;
        byte_en        = 4'b0000;
        wr_lanes       = 32'h0;
        unique case (dm_ctrl)
            F_H, F_HU: misaligned = lane[0];
            F_W:       misaligned = (lane != 2'b00);
            default:   misaligned = 1'b0;
        endcase
        unique case (dm_ctrl)
            F_B: begin
                store_width_ok = 1'b1;
                byte_en        = 4'b0001 << lane;
                wr_lanes       = {4{wr_data[7:0]}};
            end
            F_H: begin
                store_width_ok = 1'b1;
                byte_en        = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes       = {2{wr_data[15:0]}};
            end
            F_W: begin
                store_width_ok = 1'b1;
                byte_en        = 4'b1111;
                wr_lanes       = wr_data;
            end
            default: ;
        endcase
        // Illegal widths only count as faults on stores: the control unit
        // leaves dm_ctrl floating on non-memory instructions.
        fault = misaligned || (dm_write && !store_width_ok);
        wr_en = dm_write && store_width_ok && !misaligned && !rst;
    end

    // Load path: extension per funct3, zero on reset, misalignment or bad width.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case statement can infer a latch.
        rd_data = 32'h0;
        if (!rst && !misaligned) begin
            unique case (dm_ctrl)
                F_B:     rd_data = {{24{byte_sel[7]}}, byte_sel};
                F_BU:    rd_data = {24'h0, byte_sel};
                F_H:     rd_data = {{16{half_sel[15]}}, half_sel};
                F_HU:    rd_data = {16'h0, half_sel};
                F_W:     rd_data = cpu_word;
                default: rd_data = 32'h0;
            endcase
        end
    end

    // Sticky error: a new fault wins over a simultaneous clear.
    always_comb begin
        misalign_err_d = misalign_err_q;
        if (fault) begin
            misalign_err_d = 1'b1;
        end else if (err_clr) begin
            misalign_err_d = 1'b0;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block evaluation order.
        if (rst) begin
            misalign_err_q <= 1'b0;
        end else begin
            misalign_err_q <= misalign_err_d;
        end
    end

    // CPU write port: byte-masked synchronous write.
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset branch; resetting RAM contents would
        // stop it mapping onto block RAM, and its contents are don't-care.
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    // VGA read port: registered read, returns the old word on a same-cycle
    // store. The array is read directly here so the read stays synchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_data_q <= 32'h0;
        end else begin
            vga_data_q <= mem[vga_addr];
        end
    end

    assign misalign_err = misalign_err_q;
    assign vga_data     = vga_data_q;

endmodule

// File: tb/tb_data_memory.sv
// tb_data_memory: directed test of data_memory loads, stores, error flag,
// address wrap, VGA read-before-write and reset behaviour.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        dm_write;
    logic [2:0]  dm_ctrl;
    logic [31:0] rd_data;
    logic        misalign_err;
    logic        err_clr;
    logic [9:0]  vga_addr;
    logic [31:0] vga_data;

    int n_checks = 0;
    int n_fails  = 0;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    data_memory #(.DEPTH_WORDS(1024), .VGA_ADDR_W(10)) dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .wr_data      (wr_data),
        .dm_write     (dm_write),
        .dm_ctrl      (dm_ctrl),
        .rd_data      (rd_data),
        .misalign_err (misalign_err),
        .err_clr      (err_clr),
        .vga_addr     (vga_addr),
        .vga_data     (vga_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] ctrl);
        addr     = a;
        wr_data  = d;
        dm_ctrl  = ctrl;
        dm_write = 1'b1;
        step();
        dm_write = 1'b0;
        dm_ctrl  = F_B;
    endtask

    task automatic load_check(input string tag, input logic [31:0] a, input logic [2:0] ctrl,
                              input logic [31:0] exp);
        addr     = a;
        dm_ctrl  = ctrl;
        dm_write = 1'b0;
        #1;
        check(tag, rd_data, exp);
    endtask

    initial begin
        rst      = 1'b0;
        addr     = 32'h0;
        wr_data  = 32'h0;
        dm_write = 1'b0;
        dm_ctrl  = F_W;
        err_clr  = 1'b0;
        vga_addr = 10'd0;

        // 1) reset state
        #1 rst = 1'b1;
        #2;
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_misalign_err", {31'h0, misalign_err}, 32'h0);
        check("rst_vga_data", vga_data, 32'h0);
        step();
        rst     = 1'b0;
        dm_ctrl = F_B;

        // 2) word store and extended loads
        store(32'h10, 32'h80FF7F01, F_W);
        load_check("lw_10", 32'h10, F_W, 32'h80FF7F01);
        load_check("lb_13", 32'h13, F_B, 32'hFFFFFF80);
        load_check("lbu_13", 32'h13, F_BU, 32'h00000080);
        load_check("lh_12", 32'h12, F_H, 32'hFFFF80FF);
        load_check("lhu_10", 32'h10, F_HU, 32'h00007F01);
        load_check("lb_10_pos", 32'h10, F_B, 32'h00000001);
        check("no_err_after_aligned", {31'h0, misalign_err}, 32'h0);

        // 3) byte and half stores leave other lanes alone
        store(32'h11, 32'h000000AA, F_B);
        load_check("lw_after_sb", 32'h10, F_W, 32'h80FFAA01);
        store(32'h12, 32'h00001234, F_H);
        load_check("lw_after_sh", 32'h10, F_W, 32'h1234AA01);

        // 4) misaligned store suppressed, sticky error, clear, set-wins
        store(32'h14, 32'h01234567, F_W);
        addr     = 32'h16;
        wr_data  = 32'hDEADBEEF;
        dm_ctrl  = F_W;
        dm_write = 1'b1;
        #1;
        check("err_before_edge", {31'h0, misalign_err}, 32'h0);
        check("rd_misaligned_store", rd_data, 32'h0);
        step();
        dm_write = 1'b0;
        check("err_after_misaligned_sw", {31'h0, misalign_err}, 32'h1);
        load_check("word5_unchanged", 32'h14, F_W, 32'h01234567);

        addr    = 32'h0;
        dm_ctrl = F_B;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_cleared", {31'h0, misalign_err}, 32'h0);

        store(32'h20, 32'h0BADF00D, F_W);
        store(32'h20, 32'hFFFFFFFF, 3'b011);
        check("err_illegal_store", {31'h0, misalign_err}, 32'h1);
        load_check("illegal_store_no_write", 32'h20, F_W, 32'h0BADF00D);

        err_clr = 1'b1;
        load_check("lh_21_misaligned_rd", 32'h21, F_H, 32'h0);
        step();
        err_clr = 1'b0;
        check("err_set_wins_clr", {31'h0, misalign_err}, 32'h1);

        addr    = 32'h0;
        dm_ctrl = F_B;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("err_cleared_again", {31'h0, misalign_err}, 32'h0);

        load_check("illegal_load_rd", 32'h10, 3'b011, 32'h0);
        step();
        check("illegal_load_no_err", {31'h0, misalign_err}, 32'h0);
        load_check("misaligned_hu_rd", 32'h13, F_HU, 32'h0);
        dm_ctrl = F_B;

        // 5) address wrap modulo depth
        store(32'h00001004, 32'h00000055, F_W);
        load_check("lw_wrap_4", 32'h4, F_W, 32'h00000055);
        load_check("lw_10_after_wrap", 32'h10, F_W, 32'h1234AA01);

        // 6) VGA read-before-write collision
        store(32'hC, 32'h11111111, F_W);
        vga_addr = 10'd3;
        store(32'hC, 32'hCAFEF00D, F_W);
        check("vga_old_word", vga_data, 32'h11111111);
        step();
        check("vga_new_word", vga_data, 32'hCAFEF00D);
        vga_addr = 10'd4;
        step();
        check("vga_word4", vga_data, 32'h1234AA01);

        // 7) reset mid-operation discards the store and clears vga_data
        store(32'h40, 32'h00000001, F_W);
        vga_addr = 10'd16;
        step();
        check("vga_word16", vga_data, 32'h00000001);
        addr     = 32'h40;
        wr_data  = 32'h00000002;
        dm_ctrl  = F_W;
        dm_write = 1'b1;
        rst      = 1'b1;
        #1;
        check("vga_cleared_async", vga_data, 32'h0);
        check("rd_zero_in_rst", rd_data, 32'h0);
        step();
        rst      = 1'b0;
        dm_write = 1'b0;
        load_check("store_in_rst_discarded", 32'h40, F_W, 32'h00000001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
